// File: rtl/ci_burst_master_pkg.sv
// Shared types and CI field layout for the burst initiator.
package ci_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_WAIT,
      S_DELIVER
   } ci_state_e;

   localparam int SPM_DEPTH      = 512;
   localparam int CI_ADDR_WIDTH  = $clog2(SPM_DEPTH);
   localparam int CI_WRITE_BIT   = 9;
   localparam int CI_VALA_ZERO_W = 22;
   localparam int CI_VALUE_WIDTH = CI_VALA_ZERO_W + 1 + CI_ADDR_WIDTH;
   localparam int CI_COUNT_WIDTH = 10;

   // Operand A: zero-extended {write bit, word address}.
   function automatic logic [CI_VALUE_WIDTH-1:0] ci_value_a(
      input logic                     wr,
      input logic [CI_ADDR_WIDTH-1:0] addr
   );
      logic [CI_VALUE_WIDTH-1:0] v;
      v                     = '0;
      v[CI_ADDR_WIDTH-1:0]  = addr;
      v[CI_WRITE_BIT]       = wr;
      return v;
   endfunction

endpackage

// File: rtl/ci_burst_master_if.sv
// CI handshake bus between an initiator and a scratchpad responder.
interface ci_burst_master_if;
   import ci_pkg::*;

   logic                      ciStart;
   logic [7:0]                ciN;
   logic [CI_VALUE_WIDTH-1:0] ciValueA;
   logic [CI_VALUE_WIDTH-1:0] ciValueB;
   logic                      ciDone;
   logic [CI_VALUE_WIDTH-1:0] ciResult;

   modport master (output ciStart, ciN, ciValueA, ciValueB, input  ciDone, ciResult);
   modport slave  (input  ciStart, ciN, ciValueA, ciValueB, output ciDone, ciResult);

endinterface

// File: rtl/ci_burst_master_timer.sv
// Per-beat wait counter; flags the last allowed WAIT cycle.
module ci_beat_timer #(
   parameter int unsigned timeoutCycles = 64
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [15:0] LAST = 16'(timeoutCycles - 1);

   logic [15:0] count_q;

   // Count WAIT cycles since the beat was issued.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)       count_q <= '0;
      else if (clear)   count_q <= '0;
      else if (enable)  count_q <= count_q + 16'd1;
   end

   // High during the timeoutCycles-th WAIT cycle of the beat.
   assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/ci_burst_master.sv
// Block command -> one CI transaction per word, fed from / drained to word streams.
module ci_burst_master
   import ci_pkg::*;
#(
   parameter logic [7:0]  customId      = 8'h00,
   parameter int unsigned timeoutCycles = 64
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      cmdValid,
   output logic                      cmdReady,
   input  logic                      cmdWrite,
   input  logic [CI_ADDR_WIDTH-1:0]  cmdAddr,
   input  logic [CI_COUNT_WIDTH-1:0] cmdCount,
   input  logic                      wrValid,
   output logic                      wrReady,
   input  logic [31:0]               wrData,
   output logic                      rdValid,
   input  logic                      rdReady,
   output logic [31:0]               rdData,
   ci_burst_master_if.master         ci,
   output logic                      busy,
   output logic                      cmdDone,
   output logic                      error
);

   ci_state_e                 state_q, state_d;
   logic [CI_ADDR_WIDTH-1:0]  addr_q;
   logic [CI_COUNT_WIDTH-1:0] remaining_q;
   logic                      dir_q;
   logic [31:0]               value_b_q;
   logic [31:0]               rd_data_q;
   logic                      error_q;
   logic                      zero_done_q;

   logic accept, beat_done, advance, abort, last, expired;

   assign last = (remaining_q == CI_COUNT_WIDTH'(1));

   ci_beat_timer #(.timeoutCycles(timeoutCycles)) u_timer (
      .clock   (clock),
      .reset   (reset),
      .clear   (state_q == S_ISSUE),
      .enable  (state_q == S_WAIT),
      .expired (expired)
   );

   // Next state and per-cycle strobes; a beat completes in ISSUE when the
   // responder answers in the same cycle.
   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      beat_done = 1'b0;
      advance   = 1'b0;
      abort     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmdValid) begin
               accept = 1'b1;
               if (cmdCount != '0) state_d = cmdWrite ? S_FETCH : S_ISSUE;
            end
         end
         S_FETCH: begin
            if (wrValid) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            if (ci.ciDone) beat_done = 1'b1;
            else           state_d   = S_WAIT;
         end
         S_WAIT: begin
            if (ci.ciDone) beat_done = 1'b1;
            else if (expired) begin
               abort   = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_DELIVER: begin
            if (rdReady) begin
               advance = 1'b1;
               state_d = last ? S_IDLE : S_ISSUE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (beat_done) begin
         if (dir_q) begin
            advance = 1'b1;
            state_d = last ? S_IDLE : S_FETCH;
         end else begin
            state_d = S_DELIVER;
         end
      end
   end

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Command context, operand/result registers and status flags.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         addr_q      <= '0;
         remaining_q <= '0;
         dir_q       <= 1'b0;
         value_b_q   <= '0;
         rd_data_q   <= '0;
         error_q     <= 1'b0;
         zero_done_q <= 1'b0;
      end else begin
         zero_done_q <= accept && (cmdCount == '0);
         if (accept) begin
            addr_q      <= cmdAddr;
            remaining_q <= cmdCount;
            dir_q       <= cmdWrite;
            error_q     <= 1'b0;
            if (!cmdWrite) value_b_q <= '0;
         end
         if (state_q == S_FETCH && wrValid) value_b_q <= wrData;
         if (beat_done && !dir_q)           rd_data_q <= ci.ciResult;
         if (advance) begin
            addr_q      <= addr_q + CI_ADDR_WIDTH'(1);
            remaining_q <= remaining_q - CI_COUNT_WIDTH'(1);
         end
         if (abort) error_q <= 1'b1;
      end
   end

   assign cmdReady    = (state_q == S_IDLE);
   assign wrReady     = (state_q == S_FETCH);
   assign rdValid     = (state_q == S_DELIVER);
   assign busy        = (state_q != S_IDLE);
   assign rdData      = rd_data_q;
   assign error       = error_q;
   assign cmdDone     = zero_done_q | (advance && last) | abort;
   assign ci.ciStart  = (state_q == S_ISSUE);
   assign ci.ciN      = customId;
   assign ci.ciValueA = ci_value_a(dir_q, addr_q);
   assign ci.ciValueB = value_b_q;

endmodule

// File: tb/tb_ci_burst_master.sv
// Directed bench for ci_burst_master with a scratchpad responder model and scoreboards.
module tb_ci_burst_master;
   import ci_pkg::*;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
   } beat_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        cmdValid = 1'b0, cmdReady, cmdWrite = 1'b0;
   logic [8:0]  cmdAddr = '0;
   logic [9:0]  cmdCount = '0;
   logic        wrValid = 1'b0, wrReady;
   logic [31:0] wrData = '0;
   logic        rdValid, rdReady = 1'b1;
   logic [31:0] rdData;
   logic        busy, cmdDone, error;

   ci_burst_master_if ci ();

   ci_burst_master #(.customId(8'hC3), .timeoutCycles(8)) dut (
      .clock(clock), .reset(reset),
      .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdWrite(cmdWrite),
      .cmdAddr(cmdAddr), .cmdCount(cmdCount),
      .wrValid(wrValid), .wrReady(wrReady), .wrData(wrData),
      .rdValid(rdValid), .rdReady(rdReady), .rdData(rdData),
      .ci(ci),
      .busy(busy), .cmdDone(cmdDone), .error(error)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc++;

   int passed = 0, total = 0, failed = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- write word source ----------------
   logic [31:0] wr_q[$];
   bit          wr_take;
   always @(negedge clock) wr_take = wrValid && wrReady;
   always @(posedge clock) begin
      #1;
      if (wr_take && wr_q.size() != 0) void'(wr_q.pop_front());
      wrValid = (wr_q.size() != 0);
      wrData  = (wr_q.size() != 0) ? wr_q[0] : 32'h0;
   end

   // ---------------- scratchpad responder model ----------------
   logic [1:0]  resp_mode = 2'd0;   // 0 never done, 1 same-cycle done, 2 done one cycle later
   logic        start_d;
   logic [31:0] mem [512];
   bit          mem_init = 1'b0;

   always @(posedge clock or negedge reset) begin
      if (!reset) start_d <= 1'b0;
      else        start_d <= ci.ciStart;
   end

   assign ci.ciDone   = (resp_mode == 2'd1) ? ci.ciStart : (resp_mode == 2'd2) ? start_d : 1'b0;
   assign ci.ciResult = ci.ciDone ? mem[ci.ciValueA[8:0]] : 32'hDEAD_BEEF;

   always @(posedge clock) begin
      if (!mem_init) begin
         for (int i = 0; i < 512; i++) mem[i] <= 32'h1000 + 32'(i);
         mem[5]   <= 32'h11;
         mem[6]   <= 32'h22;
         mem[7]   <= 32'h33;
         mem_init <= 1'b1;
      end else if (ci.ciDone && ci.ciValueA[9]) begin
         mem[ci.ciValueA[8:0]] <= ci.ciValueB;
      end
   end

   // ---------------- scoreboards ----------------
   beat_t       exp_ci[$];
   logic [31:0] exp_rd[$];
   int          n_start = 0, start_extra = 0, rd_extra = 0;

   always @(negedge clock) begin
      beat_t e;
      if (reset && ci.ciStart) begin
         n_start++;
         if (exp_ci.size() == 0) start_extra++;
         else begin
            e = exp_ci.pop_front();
            chk("ciValueA", ci.ciValueA, e.a);
            chk("ciValueB", ci.ciValueB, e.b);
         end
      end
   end

   always @(negedge clock) begin
      if (reset && rdValid && rdReady) begin
         if (exp_rd.size() == 0) rd_extra++;
         else chk("rdData", rdData, exp_rd.pop_front());
      end
   end

   // ---------------- helpers ----------------
   task automatic send_cmd(input logic w, input logic [8:0] a, input logic [9:0] n, output int acc);
      bit ok;
      ok  = 1'b0;
      acc = 0;
      @(posedge clock); #1;
      cmdValid = 1'b1; cmdWrite = w; cmdAddr = a; cmdCount = n;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (cmdReady) begin ok = 1'b1; acc = cyc; break; end
      end
      @(posedge clock); #1;
      cmdValid = 1'b0;
      chk("cmd_accept", 32'(ok), 32'd1);
   endtask

   task automatic wait_done(input int budget, output int dc);
      bit ok;
      ok = 1'b0;
      dc = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clock);
         if (cmdDone) begin ok = 1'b1; dc = cyc; break; end
      end
      chk("cmdDone_seen", 32'(ok), 32'd1);
      @(posedge clock); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: run did not complete in time");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int acc, dc, ts, base;
      bit ok;

      // reset state
      repeat (3) @(negedge clock);
      chk("rst_cmdReady", 32'(cmdReady), 32'd1);
      chk("rst_ciStart",  32'(ci.ciStart), 32'd0);
      chk("rst_wrReady",  32'(wrReady), 32'd0);
      chk("rst_rdValid",  32'(rdValid), 32'd0);
      chk("rst_rdData",   rdData, 32'd0);
      chk("rst_busy",     32'(busy), 32'd0);
      chk("rst_cmdDone",  32'(cmdDone), 32'd0);
      chk("rst_error",    32'(error), 32'd0);
      chk("rst_valueA",   ci.ciValueA, 32'd0);
      chk("rst_valueB",   ci.ciValueB, 32'd0);
      chk("ciN",          32'(ci.ciN), 32'hC3);
      @(posedge clock); #1;
      reset = 1'b1;

      // write burst across the address wrap, same-cycle done
      resp_mode = 2'd1;
      @(negedge clock);
      for (int i = 0; i < 4; i++) wr_q.push_back(32'hA0 + 32'(i));
      exp_ci.push_back('{a:32'h3FE, b:32'hA0});
      exp_ci.push_back('{a:32'h3FF, b:32'hA1});
      exp_ci.push_back('{a:32'h200, b:32'hA2});
      exp_ci.push_back('{a:32'h201, b:32'hA3});
      base = n_start;
      send_cmd(1'b1, 9'h1FE, 10'd4, acc);
      chk("wr_busy", 32'(busy), 32'd1);
      wait_done(40, dc);
      chk("wr_done_latency", 32'(dc - acc), 32'd8);
      chk("wr_error", 32'(error), 32'd0);
      chk("wr_starts", 32'(n_start - base), 32'd4);
      chk("wr_words_left", 32'(wr_q.size()), 32'd0);
      chk("wr_busy_after", 32'(busy), 32'd0);

      // read burst, done one cycle after start
      resp_mode = 2'd2;
      exp_ci.push_back('{a:32'h005, b:32'h0});
      exp_ci.push_back('{a:32'h006, b:32'h0});
      exp_ci.push_back('{a:32'h007, b:32'h0});
      exp_rd.push_back(32'h11); exp_rd.push_back(32'h22); exp_rd.push_back(32'h33);
      base = n_start;
      send_cmd(1'b0, 9'h005, 10'd3, acc);
      wait_done(40, dc);
      chk("rd_done_latency", 32'(dc - acc), 32'd9);
      chk("rd_starts", 32'(n_start - base), 32'd3);
      chk("rd_words_left", 32'(exp_rd.size()), 32'd0);

      // read with rdReady held low: data written by the first burst, wrapped
      rdReady = 1'b0;
      exp_ci.push_back('{a:32'h1FF, b:32'h0});
      exp_ci.push_back('{a:32'h000, b:32'h0});
      exp_rd.push_back(32'hA1); exp_rd.push_back(32'hA2);
      base = n_start;
      send_cmd(1'b0, 9'h1FF, 10'd2, acc);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (rdValid) begin ok = 1'b1; break; end
      end
      chk("bp_rdValid_seen", 32'(ok), 32'd1);
      repeat (10) @(posedge clock);
      #1;
      chk("bp_hold_starts", 32'(n_start - base), 32'd1);
      chk("bp_rdValid_held", 32'(rdValid), 32'd1);
      chk("bp_rdData_held", rdData, 32'hA1);
      rdReady = 1'b1;
      wait_done(40, dc);
      chk("bp_starts", 32'(n_start - base), 32'd2);
      chk("bp_words_left", 32'(exp_rd.size()), 32'd0);

      // write with a gap in the word stream
      resp_mode = 2'd1;
      @(negedge clock);
      wr_q.push_back(32'hB0);
      exp_ci.push_back('{a:32'h210, b:32'hB0});
      exp_ci.push_back('{a:32'h211, b:32'hB1});
      exp_ci.push_back('{a:32'h212, b:32'hB2});
      base = n_start;
      send_cmd(1'b1, 9'h010, 10'd3, acc);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (wr_q.size() == 0) begin ok = 1'b1; break; end
      end
      chk("gap_first_word_taken", 32'(ok), 32'd1);
      repeat (5) @(posedge clock);
      #1;
      chk("gap_hold_starts", 32'(n_start - base), 32'd1);
      chk("gap_wrReady", 32'(wrReady), 32'd1);
      @(negedge clock);
      wr_q.push_back(32'hB1);
      wr_q.push_back(32'hB2);
      wait_done(40, dc);
      chk("gap_starts", 32'(n_start - base), 32'd3);
      chk("gap_words_left", 32'(wr_q.size()), 32'd0);

      // timeout: responder never answers
      resp_mode = 2'd0;
      exp_ci.push_back('{a:32'h020, b:32'h0});
      base = n_start;
      send_cmd(1'b0, 9'h020, 10'd2, acc);
      ok = 1'b0;
      ts = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (ci.ciStart) begin ok = 1'b1; ts = cyc; break; end
      end
      chk("to_start_seen", 32'(ok), 32'd1);
      wait_done(40, dc);
      chk("to_done_latency", 32'(dc - ts), 32'd8);
      chk("to_error", 32'(error), 32'd1);
      chk("to_busy", 32'(busy), 32'd0);
      chk("to_starts", 32'(n_start - base), 32'd1);

      // next command clears the sticky error
      resp_mode = 2'd1;
      @(negedge clock);
      wr_q.push_back(32'hC0);
      exp_ci.push_back('{a:32'h230, b:32'hC0});
      send_cmd(1'b1, 9'h030, 10'd1, acc);
      chk("clr_error", 32'(error), 32'd0);
      wait_done(20, dc);

      // zero-length command
      base = n_start;
      send_cmd(1'b1, 9'h040, 10'd0, acc);
      chk("zero_cmdDone", 32'(cmdDone), 32'd1);
      chk("zero_busy", 32'(busy), 32'd0);
      @(posedge clock); #1;
      chk("zero_cmdDone_pulse", 32'(cmdDone), 32'd0);
      chk("zero_starts", 32'(n_start - base), 32'd0);

      // asynchronous reset during WAIT of beat 2 of 4
      resp_mode = 2'd2;
      exp_ci.push_back('{a:32'h005, b:32'h0});
      exp_ci.push_back('{a:32'h006, b:32'h0});
      exp_rd.push_back(32'h11);
      send_cmd(1'b0, 9'h005, 10'd4, acc);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (rdValid) begin ok = 1'b1; break; end
      end
      chk("mr_first_word", 32'(ok), 32'd1);
      @(posedge clock); #1;
      resp_mode = 2'd0;
      @(negedge clock);
      chk("mr_beat2_start", 32'(ci.ciStart), 32'd1);
      @(negedge clock);
      #1 reset = 1'b0;
      #1;
      chk("mr_busy", 32'(busy), 32'd0);
      chk("mr_ciStart", 32'(ci.ciStart), 32'd0);
      chk("mr_rdValid", 32'(rdValid), 32'd0);
      chk("mr_valueA", ci.ciValueA, 32'd0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("mr_cmdReady", 32'(cmdReady), 32'd1);
      chk("mr_ci_left", 32'(exp_ci.size()), 32'd0);
      resp_mode = 2'd2;
      exp_ci.push_back('{a:32'h006, b:32'h0});
      exp_ci.push_back('{a:32'h007, b:32'h0});
      exp_rd.push_back(32'h22); exp_rd.push_back(32'h33);
      send_cmd(1'b0, 9'h006, 10'd2, acc);
      wait_done(40, dc);
      chk("mr_done_latency", 32'(dc - acc), 32'd6);
      chk("mr_words_left", 32'(exp_rd.size()), 32'd0);

      chk("extra_starts", 32'(start_extra), 32'd0);
      chk("extra_reads", 32'(rd_extra), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
